// File: rtl/multu_hilo_pkg.sv
// rtl/multu_hilo_pkg.sv - shared function codes and multiply FSM state encodings
package multu_hilo_pkg;

  localparam logic [5:0] FUNC_SLL   = 6'b000000;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  function automatic logic is_multu(input logic [5:0] func);
    return func == FUNC_MULTU;
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// rtl/hilo_reg.sv - Hi/Lo result register pair, loaded as one 2*WIDTH word
module hilo_reg #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [2*WIDTH-1:0] d,
  output logic [WIDTH-1:0]   HiOut,
  output logic [WIDTH-1:0]   LoOut
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HiOut <= '0;
      LoOut <= '0;
    end else if (we) begin
      HiOut <= d[2*WIDTH-1:WIDTH];
      LoOut <= d[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/multu_hilo.sv
// rtl/multu_hilo.sv - unsigned shift-add multiplier writing Hi/Lo
// MULTU_EARLY_TERM_EN: stop once the remaining multiplier bits are all zero.
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mult_state_t state, next_state;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] sum;
  logic               start;
  logic               last_iter;

  assign start = (state == IDLE) && is_multu(Signal);
  assign sum   = acc + (mplier[0] ? mcand : '0);

`ifdef MULTU_EARLY_TERM_EN
  assign last_iter = (cnt == LAST_ITER) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt == LAST_ITER);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) next_state = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_iter) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are only loaded from IDLE, so input changes mid-run never disturb them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, dataA};
      mplier <= dataB;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // The final partial product is folded in via sum on the same edge Hi/Lo load.
  hilo_reg #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk  (clk),
    .reset(reset),
    .we   ((state == BUSY) && last_iter),
    .d    (sum),
    .HiOut(HiOut),
    .LoOut(LoOut)
  );

endmodule

// File: tb/tb_multu_hilo.sv
// tb/tb_multu_hilo.sv - directed and randomized checks of multu_hilo against a product model
module tb_multu_hilo;
  import multu_hilo_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dataA, dataB;
  logic [5:0]   Signal;
  logic [W-1:0] HiOut, LoOut;
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  multu_hilo #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .dataA (dataA),
    .dataB (dataB),
    .Signal(Signal),
    .HiOut (HiOut),
    .LoOut (LoOut),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_latency(input logic [W-1:0] b);
`ifdef MULTU_EARLY_TERM_EN
    int n = 1;
    while (n < W && (b >> n) != 0) n++;
    return n;
`else
    return W;
`endif
  endfunction

  task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inject);
    logic [63:0]  exp_p;
    logic [W-1:0] hi0, lo0;
    int           lat;
    exp_p = {32'b0, a} * {32'b0, b};
    hi0 = HiOut;
    lo0 = LoOut;
    dataA  = a;
    dataB  = b;
    Signal = FUNC_MULTU;
    step();
    Signal = FUNC_ADD;
    lat = 0;
    while (busy === 1'b1 && lat < 100) begin
      lat++;
      if (lat == 5) check({tag, "_hold"}, {HiOut, LoOut}, {hi0, lo0});
      if (inject && lat == 10) begin
        dataA  = 7;
        dataB  = 7;
        Signal = FUNC_MULTU;
      end
      step();
    end
    check({tag, "_latency"}, 64'(lat), 64'(model_latency(b)));
    check({tag, "_done"}, {63'b0, done}, 64'd1);
    check({tag, "_hi"}, {32'b0, HiOut}, {32'b0, exp_p[63:32]});
    check({tag, "_lo"}, {32'b0, LoOut}, {32'b0, exp_p[31:0]});
    step();
    Signal = FUNC_ADD;
    check({tag, "_idle"}, {62'b0, busy, done}, 64'd0);
    if (inject) begin
      step();
      check({tag, "_no_requeue"}, {31'b0, busy, LoOut}, {32'b0, exp_p[31:0]});
    end
  endtask

  initial begin
    reset  = 1'b1;
    dataA  = '0;
    dataB  = '0;
    Signal = FUNC_SLL;
    step();
    step();
    reset = 1'b0;
    check("reset_out", {HiOut, LoOut}, 64'd0);
    check("reset_flags", {62'b0, busy, done}, 64'd0);

    run_mult("m3x5", 32'd3, 32'd5, 1'b0);
    run_mult("mmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_mult("ignore", 32'd3, 32'd5, 1'b1);

    Signal = FUNC_MFHI;
    step();
    Signal = FUNC_MFLO;
    step();
    check("mfhi_mflo_no_start", {63'b0, busy}, 64'd0);

    // Abort a multiply mid-flight with an asynchronous reset.
    run_mult("pre_abort", 32'd3, 32'd5, 1'b0);
    dataA  = 32'h1_0000;
    dataB  = 32'h1_0000;
    Signal = FUNC_MULTU;
    step();
    Signal = FUNC_ADD;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    #1;
    check("abort_out", {HiOut, LoOut}, 64'd0);
    check("abort_flags", {62'b0, busy, done}, 64'd0);
    step();
    reset = 1'b0;
    run_mult("after_abort", 32'd2, 32'd2, 1'b0);

    run_mult("zero_b", 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_mult("one_max", 32'd1, 32'hFFFF_FFFF, 1'b0);
    run_mult("msb_x2", 32'h8000_0000, 32'd2, 1'b0);
    run_mult("m7x2", 32'd7, 32'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (i % 3 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
      run_mult($sformatf("rnd%0d", i), ra, rb, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multu_hilo.md
MULTU_HILO -- requirements
Module: multu_hilo

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; product is 2*WIDTH bits split into Hi and Lo.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: dataA  input  WIDTH  multiplicand, unsigned.
REQ-005 SHALL have port: dataB  input  WIDTH  multiplier, unsigned.
REQ-006 SHALL have port: Signal  input  6  function code; MULTU = 6'b011001 requests a multiply.
REQ-007 SHALL have port: HiOut  output  WIDTH  Hi register, upper half of last completed product, feeds result mux for MFHI.
REQ-008 SHALL have port: LoOut  output  WIDTH  Lo register, lower half of last completed product, feeds result mux for MFLO.
REQ-009 SHALL have port: busy  output  1  high while a multiply is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse after Hi/Lo are updated.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-012 SHALL accept a start only when state is IDLE and Signal == MULTU at a rising edge (start edge, cycle 0).
REQ-013 On start SHALL capture dataA into a 2*WIDTH multiplicand register (zero-extended), dataB into a WIDTH multiplier register, clear the 2*WIDTH accumulator and iteration counter, and enter BUSY.
REQ-014 Each BUSY cycle SHALL add the multiplicand to the accumulator if multiplier bit 0 is 1, then shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
REQ-015 SHALL perform exactly WIDTH iterations (macro absent); on the edge completing the last iteration, Hi <= accumulator[2W-1:W] and Lo <= accumulator[W-1:0] (final add included), state -> DONE.
REQ-016 Latency: HiOut/LoOut update at edge WIDTH after the start edge; done high during the following cycle; DONE -> IDLE unconditionally after one cycle.
REQ-017 busy SHALL be 1 exactly while state == BUSY; done 1 exactly while state == DONE.
REQ-018 Signal == MULTU while BUSY or DONE SHALL be ignored; no queuing; the in-progress operand registers are unaffected by dataA/dataB changes.
REQ-019 All arithmetic unsigned; product of WIDTH x WIDTH fits in 2*WIDTH bits; no overflow or sign handling.
REQ-020 HiOut/LoOut SHALL hold their values between completions; they are driven directly from the Hi/Lo registers and do not change during BUSY.
REQ-021 Signal values other than MULTU (including MFHI, MFLO) SHALL have no effect on state.

Reset
REQ-022 reset high SHALL asynchronously clear HiOut, LoOut, accumulator, multiplicand, multiplier and counter to 0, busy = 0, done = 0, state = IDLE.
REQ-023 Reset mid-operation SHALL abort the multiply; no partial result reaches Hi/Lo; first start is accepted at the first rising edge with reset low.

Configuration
REQ-024 Macro MULTU_EARLY_TERM_EN defined: BUSY SHALL end on the iteration after which the shifted multiplier register is 0 (minimum 1 iteration, maximum WIDTH); Hi/Lo written on that edge; result identical to full run.
REQ-025 Macro absent: always WIDTH iterations per REQ-015; no zero-detect logic.

Structure
REQ-026 Function-code constants (MULTU, MFHI, MFLO, ADD, SUB, AND, OR, SLT, SLL) and the FSM state encodings SHALL live in the shared opcode package used by the ALU, shifter and result mux.
REQ-027 The Hi/Lo register pair (write enable, 2*WIDTH data in, HiOut/LoOut out, async reset) SHALL be a sub-module named hilo_reg; the FSM and shift-add datapath stay in multu_hilo.

Verification
REQ-028 Assert reset, release -> HiOut = 0, LoOut = 0, busy = 0, done = 0.
REQ-029 MULTU with dataA = 3, dataB = 5 -> busy for 32 cycles, then HiOut = 0x00000000, LoOut = 0x0000000F, done high one cycle.
REQ-030 MULTU with dataA = dataB = 0xFFFFFFFF -> HiOut = 0xFFFFFFFE, LoOut = 0x00000001 at edge 32 after start.
REQ-031 Start 3x5, then Signal = MULTU with dataA = dataB = 7 at cycle 10 and in DONE -> result remains Lo = 15; second request ignored, busy never re-asserts.
REQ-032 Complete 3x5, start 0x10000 x 0x10000, assert reset at cycle 10 -> HiOut = 0, LoOut = 0, state IDLE; new 2x2 start afterwards yields Lo = 4.
REQ-033 MULTU_EARLY_TERM_EN defined: dataA = 7, dataB = 2 -> busy exactly 2 cycles, LoOut = 14; dataB = 0 -> busy 1 cycle, Hi = Lo = 0.
